multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Multi-cycle sequencer for the 24-bit CPU datapath, replacing single-cycle decode with a registered FSM. One shared memory port serves both instruction fetch and data access, handshaked via MemReady. Each cycle it drives the datapath control strobes (RegDst, ALUsrc, MemToReg, RegWrite, MemRead, MemWrite, ALUop, PC/IR enables) and retires one instruction per sequence. It also counts retired instructions and traps halt, illegal-opcode and memory-timeout conditions.

Parameters:
MEM_TIMEOUT, 16, max wait cycles for MemReady per memory access before error (>=2)
CNT_W, 16, width of retired-instruction counter

Ports:
Clock  input  1  system clock, rising edge
ResetN  input  1  asynchronous active-low reset
Run  input  1  leave IDLE and start fetching when 1
OPcode  input  4  IR[23:20], valid from DECODE onward
Zero  input  1  ALU zero flag
MemReady  input  1  memory completes current access this cycle
PCEn  output  1  PC load enable = PCWrite | (PCWriteCond & Zero), combinational
PCSource  output  1  0 = ALU result (PC+1), 1 = ALUOut (branch target)
IorD  output  1  memory address: 0 = PC, 1 = ALUOut
IRWrite  output  1  load instruction register
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
MemToReg  output  1  write-back source: 0 = ALUOut, 1 = MDR
RegDst  output  1  destination: 0 = rt, 1 = rd
RegWrite  output  1  register file write
ALUsrcA  output  1  0 = PC, 1 = register A
ALUsrcB  output  2  00 = reg B, 01 = constant 1, 10 = sign-extended imm
ALUop  output  2  00 add, 01 sub, 10 funct-decoded
Busy  output  1  1 in every state except IDLE, HALT, ERROR
Halted  output  1  1 in HALT
ErrCode  output  2  00 none, 01 illegal opcode, 10 memory timeout
InstrCount  output  CNT_W  retired instructions, wraps modulo 2^CNT_W
State  output  4  current state encoding (debug)

Behaviour:
- Reset (ResetN=0, async): state IDLE, InstrCount=0, wait counter=0, ErrCode=00; all strobes 0, ALUsrcB=00, ALUop=00. Reset mid-access drops MemRead/MemWrite immediately.
- Moore outputs decoded from state register only (except PCEn, which uses Zero). MemReady and OPcode sampled at rising edge.
- Opcode map: 0110 R-format, 0001 addi, 0010 ls, 0011 ss, 0100 beq, 1111 halt; all others illegal.
- IDLE: strobes 0; Run=1 -> FETCH.
- FETCH: MemRead=1, IorD=0, ALUsrcA=0, ALUsrcB=01, ALUop=00. Stays while MemReady=0. On MemReady=1, same cycle: IRWrite=1, PCWrite=1, PCSource=0 -> DECODE. IRWrite/PCWrite are 0 in wait cycles.
- DECODE (1 cycle): ALUsrcA=0, ALUsrcB=10, ALUop=00 (branch target into ALUOut). Next: 0110 -> EXEC_R; 0001 -> EXEC_I; 0010/0011 -> MEM_ADDR; 0100 -> BRANCH; 1111 -> HALT; else -> ERROR with ErrCode=01.
- EXEC_R: ALUsrcA=1, ALUsrcB=00, ALUop=10 -> WB_R.
- EXEC_I and MEM_ADDR: ALUsrcA=1, ALUsrcB=10, ALUop=00. EXEC_I -> WB_I. MEM_ADDR -> MEM_RD (0010) or MEM_WR (0011).
- MEM_RD: MemRead=1, IorD=1; wait for MemReady -> WB_MEM.
- MEM_WR: MemWrite=1, IorD=1; wait for MemReady -> FETCH, retire.
- WB_R: RegWrite=1, RegDst=1, MemToReg=0. WB_I: RegWrite=1, RegDst=0, MemToReg=0. WB_MEM: RegWrite=1, RegDst=0, MemToReg=1. Each -> FETCH, retire.
- BRANCH: ALUsrcA=1, ALUsrcB=00, ALUop=01, PCWriteCond=1, PCSource=1 -> FETCH, retire (taken or not).
- Retire: InstrCount += 1 on the exit edge of MEM_WR, WB_*, BRANCH. Halt and illegal do not retire.
- Wait counter: cleared on entry to FETCH/MEM_RD/MEM_WR; increments each cycle with MemReady=0. If it reaches MEM_TIMEOUT-1 with MemReady=0 -> ERROR, ErrCode=10, strobes drop next cycle. MemReady=1 on that same cycle wins (access completes).
- HALT, ERROR: sticky, all strobes 0, Run ignored; exit only via ResetN.
- Never both MemRead and MemWrite; RegWrite never asserted in a memory-request state.

Test Plan:
- Reset then Run=1, MemReady=1 constant, OPcode=0110 -> states FETCH, DECODE, EXEC_R, WB_R, FETCH; RegWrite=1, RegDst=1 in WB_R only; InstrCount=1 after 4 cycles.
- ls (0010) with MemReady low 3 cycles in MEM_RD -> MemRead=1, IorD=1 held 4 cycles; then WB_MEM with MemToReg=1, RegWrite=1; InstrCount increments once.
- beq (0100): Zero=1 -> PCEn=1, PCSource=1 in BRANCH; Zero=0 -> PCEn=0; both return to FETCH and retire.
- OPcode=1010 -> ERROR after DECODE, ErrCode=01, Busy=0, InstrCount unchanged; Run toggling ignored; OPcode=1111 -> Halted=1.
- MEM_TIMEOUT=16, MemReady held 0 in FETCH -> ERROR at wait count 15, ErrCode=10; MemReady=1 exactly on count 15 -> DECODE, no error.
- ResetN pulsed low during MEM_WR wait -> MemWrite=0 immediately, state IDLE, InstrCount=0; 16-bit counter at 0xFFFF wraps to 0x0000 on next retire.

Source files
------------

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle control sequencer for the 24-bit CPU datapath
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Run,
    input  logic [3:0]       OPcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCEn,
    output logic             PCSource,
    output logic             IorD,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             ALUsrcA,
    output logic [1:0]       ALUsrcB,
    output logic [1:0]       ALUop,
    output logic             Busy,
    output logic             Halted,
    output logic [1:0]       ErrCode,
    output logic [CNT_W-1:0] InstrCount,
    output logic [3:0]       State
);

    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [3:0] OP_R    = 4'b0110;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_LS   = 4'b0010;
    localparam logic [3:0] OP_SS   = 4'b0011;
    localparam logic [3:0] OP_BEQ  = 4'b0100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        EXEC_R   = 4'd3,
        EXEC_I   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WR   = 4'd7,
        WB_R     = 4'd8,
        WB_I     = 4'd9,
        WB_MEM   = 4'd10,
        BRANCH   = 4'd11,
        HALT     = 4'd12,
        ERROR    = 4'd13
    } state_t;

    state_t            state;
    state_t            nextState;
    logic [WAIT_W-1:0] waitCnt;
    logic              memState;
    logic              timeout;
    logic              retire;
    logic              pcWrite;
    logic              pcWriteCond;

    assign memState = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    // MemReady on the final wait cycle still completes the access.
    assign timeout  = memState && !MemReady && (waitCnt == WAIT_LIMIT);
    assign retire   = ((state == MEM_WR) && MemReady) || (state == WB_R) ||
                      (state == WB_I) || (state == WB_MEM) || (state == BRANCH);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:     if (Run) nextState = FETCH;
            FETCH:    if (MemReady) nextState = DECODE;
                      else if (timeout) nextState = ERROR;
            DECODE: begin
                case (OPcode)
                    OP_R:         nextState = EXEC_R;
                    OP_ADDI:      nextState = EXEC_I;
                    OP_LS, OP_SS: nextState = MEM_ADDR;
                    OP_BEQ:       nextState = BRANCH;
                    OP_HALT:      nextState = HALT;
                    default:      nextState = ERROR;
                endcase
            end
            EXEC_R:   nextState = WB_R;
            EXEC_I:   nextState = WB_I;
            MEM_ADDR: nextState = (OPcode == OP_SS) ? MEM_WR : MEM_RD;
            MEM_RD:   if (MemReady) nextState = WB_MEM;
                      else if (timeout) nextState = ERROR;
            MEM_WR:   if (MemReady) nextState = FETCH;
                      else if (timeout) nextState = ERROR;
            WB_R, WB_I, WB_MEM, BRANCH: nextState = FETCH;
            HALT:     nextState = HALT;
            ERROR:    nextState = ERROR;
            default:  nextState = ERROR;
        endcase
    end

    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        PCSource    = 1'b0;
        IorD        = 1'b0;
        IRWrite     = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUsrcA     = 1'b0;
        ALUsrcB     = 2'b00;
        ALUop       = 2'b00;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUsrcB = 2'b01;
                IRWrite = MemReady;
                pcWrite = MemReady;
            end
            DECODE:   ALUsrcB = 2'b10;
            EXEC_R: begin
                ALUsrcA = 1'b1;
                ALUop   = 2'b10;
            end
            EXEC_I, MEM_ADDR: begin
                ALUsrcA = 1'b1;
                ALUsrcB = 2'b10;
            end
            MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            WB_R: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            WB_I:     RegWrite = 1'b1;
            WB_MEM: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            BRANCH: begin
                ALUsrcA     = 1'b1;
                ALUop       = 2'b01;
                pcWriteCond = 1'b1;
                PCSource    = 1'b1;
            end
            default: ;
        endcase
    end

    assign PCEn   = pcWrite | (pcWriteCond & Zero);
    assign Busy   = (state != IDLE) && (state != HALT) && (state != ERROR);
    assign Halted = (state == HALT);
    assign State  = state;

    // Wait counter restarts on every state change so each access gets a fresh budget.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            waitCnt <= '0;
        end else if (state != nextState) begin
            waitCnt <= '0;
        end else if (memState && !MemReady) begin
            waitCnt <= waitCnt + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            ErrCode <= 2'b00;
        end else if ((state == DECODE) && (nextState == ERROR)) begin
            ErrCode <= 2'b01;
        end else if (timeout) begin
            ErrCode <= 2'b10;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            InstrCount <= '0;
        end else if (retire) begin
            InstrCount <= InstrCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
                           S_EXEC_I = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WR = 4'd7,
                           S_WB_R = 4'd8, S_WB_I = 4'd9, S_WB_MEM = 4'd10, S_BRANCH = 4'd11,
                           S_HALT = 4'd12, S_ERROR = 4'd13;

    logic        Clock, ResetN, Run, Zero, MemReady;
    logic [3:0]  OPcode;
    logic        PCEn, PCSource, IorD, IRWrite, MemRead, MemWrite, MemToReg, RegDst, RegWrite;
    logic        ALUsrcA, Busy, Halted;
    logic [1:0]  ALUsrcB, ALUop, ErrCode;
    logic [15:0] InstrCount;
    logic [3:0]  State;

    logic        pcEn2, pcSrc2, iorD2, irWr2, mRd2, mWr2, m2r2, rDst2, rWr2, aA2, busy2, halt2;
    logic [1:0]  aB2, aOp2, err2;
    logic [3:0]  cnt2, state2;

    int vecs = 0;
    int errs = 0;

    multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .Clock(Clock), .ResetN(ResetN), .Run(Run), .OPcode(OPcode), .Zero(Zero),
        .MemReady(MemReady), .PCEn(PCEn), .PCSource(PCSource), .IorD(IorD),
        .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUsrcA(ALUsrcA), .ALUsrcB(ALUsrcB),
        .ALUop(ALUop), .Busy(Busy), .Halted(Halted), .ErrCode(ErrCode),
        .InstrCount(InstrCount), .State(State)
    );

    // Narrow counter copy shares all stimulus so its wrap is reachable quickly.
    multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(4)) dutNarrow (
        .Clock(Clock), .ResetN(ResetN), .Run(Run), .OPcode(OPcode), .Zero(Zero),
        .MemReady(MemReady), .PCEn(pcEn2), .PCSource(pcSrc2), .IorD(iorD2),
        .IRWrite(irWr2), .MemRead(mRd2), .MemWrite(mWr2), .MemToReg(m2r2),
        .RegDst(rDst2), .RegWrite(rWr2), .ALUsrcA(aA2), .ALUsrcB(aB2),
        .ALUop(aOp2), .Busy(busy2), .Halted(halt2), .ErrCode(err2),
        .InstrCount(cnt2), .State(state2)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge Clock);
        #1;
    endtask

    initial begin
        ResetN = 1'b0; Run = 1'b0; OPcode = 4'b0000; Zero = 1'b0; MemReady = 1'b1;
        step(2);
        chk("rst_state", State, S_IDLE);
        chk("rst_count", InstrCount, 16'h0000);
        chk("rst_err", ErrCode, 2'b00);
        chk("rst_memread", MemRead, 1'b0);
        chk("rst_busy", Busy, 1'b0);

        // R-format with memory always ready
        ResetN = 1'b1; Run = 1'b1; OPcode = 4'b0110;
        step(1);
        chk("r_fetch", State, S_FETCH);
        chk("r_fetch_irwrite", IRWrite, 1'b1);
        chk("r_fetch_pcen", PCEn, 1'b1);
        chk("r_fetch_alub", ALUsrcB, 2'b01);
        step(1);
        chk("r_decode", State, S_DECODE);
        chk("r_decode_alub", ALUsrcB, 2'b10);
        chk("r_decode_regwrite", RegWrite, 1'b0);
        step(1);
        chk("r_exec", State, S_EXEC_R);
        chk("r_exec_aluop", ALUop, 2'b10);
        chk("r_exec_srca", ALUsrcA, 1'b1);
        step(1);
        chk("r_wb", State, S_WB_R);
        chk("r_wb_ctl", {RegWrite, RegDst, MemToReg}, 3'b110);
        step(1);
        chk("r_back_fetch", State, S_FETCH);
        chk("r_count", InstrCount, 16'd1);
        chk("r_fetch_regwrite", RegWrite, 1'b0);

        // load with three wait cycles in MEM_RD
        OPcode = 4'b0010;
        step(2);
        chk("ls_addr", State, S_MEM_ADDR);
        MemReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("ls_wait_state", State, S_MEM_RD);
            chk("ls_wait_ctl", {MemRead, MemWrite, IorD, RegWrite}, 4'b1010);
        end
        MemReady = 1'b1;
        #1;
        chk("ls_last_memread", MemRead, 1'b1);
        step(1);
        chk("ls_wbmem", State, S_WB_MEM);
        chk("ls_wbmem_ctl", {RegWrite, MemToReg, RegDst, MemRead}, 4'b1100);
        chk("ls_count_pre", InstrCount, 16'd1);
        step(1);
        chk("ls_count", InstrCount, 16'd2);

        // branch: taken then not-taken view of PCEn in the same BRANCH cycle
        OPcode = 4'b0100; Zero = 1'b1;
        step(2);
        chk("beq_state", State, S_BRANCH);
        chk("beq_taken_pcen", PCEn, 1'b1);
        chk("beq_pcsrc", PCSource, 1'b1);
        chk("beq_aluop", ALUop, 2'b01);
        Zero = 1'b0;
        #1;
        chk("beq_nottaken_pcen", PCEn, 1'b0);
        step(1);
        chk("beq_back_fetch", State, S_FETCH);
        chk("beq_count", InstrCount, 16'd3);

        // MemReady arrives exactly on the last allowed wait cycle
        MemReady = 1'b0;
        step(15);
        chk("to_edge_state", State, S_FETCH);
        chk("to_edge_irwrite", IRWrite, 1'b0);
        MemReady = 1'b1; OPcode = 4'b0001;
        step(1);
        chk("to_edge_decode", State, S_DECODE);
        chk("to_edge_err", ErrCode, 2'b00);
        step(1);
        chk("addi_exec", State, S_EXEC_I);
        step(1);
        chk("addi_wb", State, S_WB_I);
        chk("addi_wb_ctl", {RegWrite, RegDst, MemToReg}, 3'b100);
        step(1);
        chk("addi_count", InstrCount, 16'd4);

        // full timeout in FETCH
        MemReady = 1'b0;
        step(15);
        chk("to_pre_state", State, S_FETCH);
        step(1);
        chk("to_state", State, S_ERROR);
        chk("to_err", ErrCode, 2'b10);
        chk("to_memread", MemRead, 1'b0);
        chk("to_busy", Busy, 1'b0);
        chk("to_count", InstrCount, 16'd4);

        // illegal opcode, then Run toggling must not matter
        ResetN = 1'b0; MemReady = 1'b1; OPcode = 4'b1010;
        step(1);
        ResetN = 1'b1;
        step(3);
        chk("ill_state", State, S_ERROR);
        chk("ill_err", ErrCode, 2'b01);
        chk("ill_busy", Busy, 1'b0);
        chk("ill_count", InstrCount, 16'd0);
        Run = 1'b0;
        step(1);
        Run = 1'b1;
        step(2);
        chk("ill_sticky", State, S_ERROR);

        // halt
        ResetN = 1'b0; OPcode = 4'b1111;
        step(1);
        ResetN = 1'b1;
        step(3);
        chk("halt_state", State, S_HALT);
        chk("halt_flag", Halted, 1'b1);
        chk("halt_busy", Busy, 1'b0);
        chk("halt_count", InstrCount, 16'd0);

        // store: one completes, second is cut by reset mid-wait
        ResetN = 1'b0; OPcode = 4'b0011;
        step(1);
        ResetN = 1'b1;
        step(4);
        chk("ss_state", State, S_MEM_WR);
        chk("ss_ctl", {MemWrite, MemRead, IorD, RegWrite}, 4'b1010);
        step(1);
        chk("ss_back_fetch", State, S_FETCH);
        chk("ss_count", InstrCount, 16'd1);
        step(2);
        MemReady = 1'b0;
        step(2);
        chk("ss_wait_memwrite", MemWrite, 1'b1);
        ResetN = 1'b0;
        #1;
        chk("ss_rst_memwrite", MemWrite, 1'b0);
        chk("ss_rst_state", State, S_IDLE);
        chk("ss_rst_count", InstrCount, 16'd0);

        // counter wrap on the narrow instance
        step(1);
        ResetN = 1'b1; MemReady = 1'b1; OPcode = 4'b0100; Zero = 1'b0;
        step(1);
        step(3 * 15);
        chk("wrap_pre_narrow", cnt2, 4'hF);
        step(3);
        chk("wrap_narrow", cnt2, 4'h0);
        chk("wrap_wide", InstrCount, 16'd16);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
